// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings for the data-memory load/store controller.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_t;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LD_DATA,
    MERGE,
    WRITE,
    RESP
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane extraction/extension for loads and lane merge for sub-word stores.
module dmem_lane_align
  import dmem_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      lane,
  input  size_t           size,
  input  logic            is_unsigned,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_val,
  output logic [XLEN-1:0] merged
);

  logic [4:0]      bit_off;
  logic [4:0]      half_off;
  logic [XLEN-1:0] shifted;
  logic [7:0]      lane_byte;
  logic [15:0]     lane_half;

  assign bit_off   = {lane, 3'b000};
  assign half_off  = {lane[1], 4'b0000};
  assign shifted   = word >> bit_off;
  assign lane_byte = shifted[7:0];
  assign lane_half = shifted[15:0];

  always_comb begin
    load_val = word;
    case (size)
      SZ_B:    load_val = {{(XLEN-8){~is_unsigned & lane_byte[7]}}, lane_byte};
      SZ_H:    load_val = {{(XLEN-16){~is_unsigned & lane_half[15]}}, lane_half};
      default: load_val = word;
    endcase
  end

  always_comb begin
    merged = word;
    case (size)
      SZ_B:    merged[bit_off +: 8]   = wdata[7:0];
      SZ_H:    merged[half_off +: 16] = wdata[15:0];
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store controller in front of a word-addressed data memory with 1-cycle registered read.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              dmem_ren,
  output logic [ADDR_W-1:0] dmem_raddr,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              dmem_wen,
  output logic [ADDR_W-1:0] dmem_waddr,
  output logic [XLEN-1:0]   dmem_wdata
);

  state_t            state_q, state_d;
  logic              we_q, uns_q, err_q;
  size_t             size_q;
  logic [1:0]        lane_q;
  logic [ADDR_W-1:0] widx_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   rdata_q;

  logic              accept;
  logic              req_err;
  size_t             req_sz;
  logic [XLEN-1:0]   load_val;
  logic [XLEN-1:0]   merged;

  assign req_sz    = size_t'(req_size);
  assign req_ready = (state_q == IDLE) && rst_n;
  assign accept    = req_valid && req_ready;

  always_comb begin
    req_err = 1'b0;
    if (req_sz == SZ_X)                          req_err = 1'b1;
    if (req_sz == SZ_H && req_addr[0])           req_err = 1'b1;
    if (req_sz == SZ_W && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if (req_addr[31:ADDR_W+2] != '0)             req_err = 1'b1;
  end

  dmem_lane_align #(
    .XLEN(XLEN)
  ) u_align (
    .word        (dmem_rdata),
    .lane        (lane_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .load_val    (load_val),
    .merged      (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_B;
      lane_q  <= '0;
      widx_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        err_q   <= req_err;
        size_q  <= req_sz;
        lane_q  <= req_addr[1:0];
        widx_q  <= req_addr[ADDR_W+1:2];
        wdata_q <= req_wdata;
        rdata_q <= '0;
      end else if (state_q == LD_DATA) begin
        rdata_q <= load_val;
      end
    end
  end

  // Every output is decoded from state so an asynchronous reset clears them at once.
  always_comb begin
    state_d    = state_q;
    dmem_ren   = 1'b0;
    dmem_raddr = '0;
    dmem_wen   = 1'b0;
    dmem_waddr = '0;
    dmem_wdata = '0;
    rsp_valid  = 1'b0;
    rsp_err    = 1'b0;
    rsp_rdata  = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)                     state_d = RESP;
          else if (req_we && req_sz == SZ_W) state_d = WRITE;
          else                             state_d = READ;
        end
      end
      READ: begin
        dmem_ren   = 1'b1;
        dmem_raddr = widx_q;
        state_d    = we_q ? MERGE : LD_DATA;
      end
      LD_DATA: begin
        state_d = RESP;
      end
      MERGE: begin
        dmem_wen   = 1'b1;
        dmem_waddr = widx_q;
        dmem_wdata = merged;
        state_d    = RESP;
      end
      WRITE: begin
        dmem_wen   = 1'b1;
        dmem_waddr = widx_q;
        dmem_wdata = wdata_q;
        state_d    = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = rdata_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized self-checking bench for dmem_ctrl against a byte-level reference memory model.
module tb_dmem_ctrl;

  localparam int ADDR_W = 14;
  localparam int XLEN   = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_unsigned = 1'b0;
  logic [31:0]       req_addr = '0;
  logic [XLEN-1:0]   req_wdata = '0;
  logic              rsp_valid, rsp_err;
  logic [XLEN-1:0]   rsp_rdata;
  logic              dmem_ren, dmem_wen;
  logic [ADDR_W-1:0] dmem_raddr, dmem_waddr;
  logic [XLEN-1:0]   dmem_rdata, dmem_wdata;

  int n_checks = 0;
  int n_pass   = 0;

  dmem_ctrl #(.ADDR_W(ADDR_W), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .dmem_ren(dmem_ren), .dmem_raddr(dmem_raddr), .dmem_rdata(dmem_rdata),
    .dmem_wen(dmem_wen), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int unsigned i);
    return (i * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Data memory model: whole-word writes, registered read.
  logic [31:0] mem [DEPTH];
  logic [31:0] mem_rd = '0;
  assign dmem_rdata = mem_rd;
  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (dmem_ren) mem_rd <= mem[dmem_raddr];
      if (dmem_wen) mem[dmem_waddr] = dmem_wdata;
    end
  end

  // Bus monitor sampled on the falling edge.
  int          ren_cnt = 0, wen_cnt = 0, rsp_cnt = 0, rule_bad = 0;
  logic [31:0] last_waddr = '0, last_wdata = '0;
  always @(negedge clk) begin
    if (dmem_ren) ren_cnt++;
    if (dmem_wen) begin
      wen_cnt++;
      last_waddr = 32'(dmem_waddr);
      last_wdata = dmem_wdata;
    end
    if (rsp_valid) rsp_cnt++;
    if (dmem_ren && dmem_wen) rule_bad++;
    if (!dmem_ren && dmem_raddr != '0) rule_bad++;
    if (!dmem_wen && (dmem_waddr != '0 || dmem_wdata != '0)) rule_bad++;
    if (!rsp_valid && (rsp_err || rsp_rdata != '0)) rule_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference model: byte-addressed view of memory.
  logic [7:0] ref_b [DEPTH*4];

  function automatic bit ref_is_err(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b11) return 1'b1;
    if (sz == 2'b01 && a % 2 != 0) return 1'b1;
    if (sz == 2'b10 && a % 4 != 0) return 1'b1;
    return a >= 32'(DEPTH * 4);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit uns, input logic [31:0] a);
    int unsigned v;
    int unsigned nbytes;
    nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    v = 0;
    for (int unsigned k = 0; k < nbytes; k++) v += int'(ref_b[a + k]) << (8 * k);
    if (!uns && nbytes == 1 && v >= 128)   v += 32'hFFFF_FF00;
    if (!uns && nbytes == 2 && v >= 32768) v += 32'hFFFF_0000;
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int unsigned nbytes;
    nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    for (int unsigned k = 0; k < nbytes; k++) ref_b[a + k] = 8'((d >> (8 * k)) & 32'hFF);
  endtask

  // Issue one request starting at a falling edge; returns at the falling edge after RESP.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d, input bit hold);
    int  n, lat, ren0, wen0;
    bit  busy_ok, err;
    logic [31:0] exp_rd;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    ren0 = ren_cnt; wen0 = wen_cnt;
    @(posedge clk);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    lat = 1; busy_ok = 1'b1;
    while (!rsp_valid && lat < 10) begin
      if (req_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (req_ready) busy_ok = 1'b0;
    err    = ref_is_err(sz, a);
    exp_rd = (!err && !we) ? ref_load(sz, uns, a) : 32'd0;
    chk("latency", 32'(lat), err ? 32'd1 : (we && sz == 2'b10) ? 32'd2 : 32'd3);
    chk("rsp_err", 32'(rsp_err), 32'(err));
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("busy_not_ready", 32'(busy_ok), 32'd1);
    chk("ren_count", 32'(ren_cnt - ren0), (err || (we && sz == 2'b10)) ? 32'd0 : 32'd1);
    chk("wen_count", 32'(wen_cnt - wen0), (!err && we) ? 32'd1 : 32'd0);
    if (!err && we) ref_store(sz, a, d);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [1:0]  sz;
    int          r0, w0;

    for (int unsigned i = 0; i < DEPTH; i++)
      for (int unsigned k = 0; k < 4; k++) ref_b[4*i + k] = 8'((init_word(i) >> (8 * k)) & 32'hFF);

    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_strobes", {30'd0, dmem_ren, dmem_wen}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
    chk("sw_waddr", last_waddr, 32'd4);
    chk("sw_wdata", last_wdata, 32'hDEAD_BEEF);
    do_req(1'b0, 2'b00, 1'b0, 32'h13, '0, 1'b0);
    chk("lb_value", rsp_cnt > 0 ? ref_load(2'b00, 1'b0, 32'h13) : '0, 32'hFFFF_FFDE);
    do_req(1'b0, 2'b00, 1'b1, 32'h13, '0, 1'b0);
    do_req(1'b0, 2'b01, 1'b0, 32'h12, '0, 1'b0);
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h55, 1'b0);
    chk("sb_merge_wdata", last_wdata, 32'hDEAD_55EF);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, '0, 1'b0);

    do_req(1'b0, 2'b10, 1'b0, 32'h02, '0, 1'b0);
    do_req(1'b1, 2'b01, 1'b0, 32'h01, 32'h1234, 1'b0);
    do_req(1'b0, 2'b11, 1'b0, 32'h20, '0, 1'b0);
    do_req(1'b0, 2'b10, 1'b0, 32'h0001_0000, '0, 1'b0);

    // Reset while an SB sits in READ: no write, no response, word untouched.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h24; req_wdata = 32'hA5;
    w0 = wen_cnt; r0 = rsp_cnt;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_ren", 32'(dmem_ren), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ren", 32'(dmem_ren), 32'd0);
    chk("mid_rst_raddr", 32'(dmem_raddr), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready_back", 32'(req_ready), 32'd1);
    chk("mid_rst_no_wen", 32'(wen_cnt - w0), 32'd0);
    chk("mid_rst_no_rsp", 32'(rsp_cnt - r0), 32'd0);
    chk("mid_rst_word", mem[9], {ref_b[39], ref_b[38], ref_b[37], ref_b[36]});
    do_req(1'b0, 2'b00, 1'b1, 32'h24, '0, 1'b0);

    for (int i = 0; i < 6; i++) do_req(1'b0, 2'b10, 1'b0, 32'(4 * i), '0, 1'b1);
    req_valid = 1'b0;

    for (int i = 0; i < 300; i++) begin
      sz = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1, 2, 3: a = $urandom_range(0, 32'hFFFF);
        default: a = $urandom_range(0, 255);
      endcase
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a = a & ~32'd1;
        if (sz == 2'b10) a = a & ~32'd3;
      end
      d = $urandom;
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, d,
             bit'($urandom_range(0, 1)));
    end
    req_valid = 1'b0;
    repeat (2) @(negedge clk);

    r0 = 0;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (mem[i] !== {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]}) r0++;
    chk("mem_image_diffs", 32'(r0), 32'd0);
    chk("strobe_rules", 32'(rule_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
